// File: rtl/mem_if_pkg.sv
// Shared types for the data-port memory responder: FSM states and the
// request record captured at acceptance.
package mem_if_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_req_t;

endpackage

// File: rtl/be_word_ram.sv
// Word-organised storage with per-byte write enables; write on the rising
// edge, read combinationally.
module be_word_ram
   import mem_if_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_r [MEM_DEPTH];

   // Byte-lane write: only lanes with their enable set are touched.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) begin
               mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency, valid/ready handshaked slave for the CPU data port:
// one request in flight, committed LATENCY cycles after acceptance.
module data_mem_responder
   import mem_if_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [31:0] DEPTH_W  = 32'(MEM_DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_t      state_r;
   logic [3:0]  cnt_r;
   mem_req_t    req_r;
   logic        req_ready_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic        resp_err_r;

   logic          err_s;
   logic          commit_s;
   logic          ram_we_s;
   logic [AW-1:0] ram_addr_s;
   logic [31:0]   ram_rdata_s;

   // Error and commit qualification on the captured request; reset blocks
   // a write that would otherwise land on the same edge.
   always_comb begin
      err_s      = 1'b0;
      commit_s   = 1'b0;
      ram_we_s   = 1'b0;
      ram_addr_s = req_r.addr[AW+1:2];
      if ((req_r.addr[1:0] != 2'b00) || ({2'b00, req_r.addr[31:2]} >= DEPTH_W)) begin
         err_s = 1'b1;
      end else begin
         err_s = 1'b0;
      end
      if ((state_r == BUSY) && (cnt_r == 4'd0)) begin
         commit_s = 1'b1;
      end else begin
         commit_s = 1'b0;
      end
      if (commit_s && req_r.we && !err_s && !reset) begin
         ram_we_s = 1'b1;
      end else begin
         ram_we_s = 1'b0;
      end
   end

   be_word_ram #(
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .be    (req_r.be),
      .waddr (ram_addr_s),
      .wdata (req_r.wdata),
      .raddr (ram_addr_s),
      .rdata (ram_rdata_s)
   );

   // Request/response FSM with latency counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         req_r        <= '{we: 1'b0, addr: 32'h0000_0000, wdata: 32'h0000_0000, be: 4'h0};
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready_r) begin
                  req_r       <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                  cnt_r       <= CNT_INIT;
                  req_ready_r <= 1'b0;
                  state_r     <= BUSY;
               end
            end
            BUSY: begin
               if (commit_s) begin
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= err_s;
                  resp_rdata_r <= (err_s || req_r.we) ? 32'h0000_0000 : ram_rdata_s;
                  state_r      <= RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_r <= 1'b0;
                  req_ready_r  <= 1'b1;
                  state_r      <= IDLE;
               end
            end
            default: begin
               state_r      <= IDLE;
               cnt_r        <= 4'd0;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with LATENCY=2, MEM_DEPTH=1024.
module tb_data_mem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [3:0]  req_be = 4'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   data_mem_responder #(.MEM_DEPTH(1024), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full transaction; inputs are scrambled right after acceptance.
   task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      int lat;
      logic [31:0] held;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
      tick();
      req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC;
      req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
      check({tag, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
      lat = 0;
      while (!resp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_rdata"}, resp_rdata, exp_rdata);
      check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
         check({tag, "_hold_rdata"}, resp_rdata, held);
         check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, "_post_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_post_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int seen;
      tick();
      tick();
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      reset = 1'b0;
      tick();

      // A stray resp_ready while idle must not produce anything.
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("idle_rr_valid", {31'd0, resp_valid}, 32'd0);
      check("idle_rr_ready", {31'd0, req_ready}, 32'd1);

      xact("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
      xact("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);
      xact("wr10_be5", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, 32'h0, 1'b0);
      xact("rd10_be5", 1'b0, 32'h10, 32'h0, 4'hF, 0, 32'hDE22_BE44, 1'b0);
      xact("wr10_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, 1'b0);
      xact("rd10_be0", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22_BE44, 1'b0);

      xact("rd13", 1'b0, 32'h13, 32'h0, 4'hF, 0, 32'h0, 1'b1);
      xact("wr12", 1'b1, 32'h12, 32'h0000_0000, 4'hF, 0, 32'h0, 1'b1);
      xact("rd10_mis", 1'b0, 32'h10, 32'h0, 4'hF, 0, 32'hDE22_BE44, 1'b0);
      xact("wrffc", 1'b1, 32'hFFC, 32'h0BAD_F00D, 4'hF, 0, 32'h0, 1'b0);
      xact("wr000", 1'b1, 32'h000, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0);
      xact("wr1000", 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1);
      xact("rd1000", 1'b0, 32'h1000, 32'h0, 4'hF, 0, 32'h0, 1'b1);
      xact("rdffc", 1'b0, 32'hFFC, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0);
      xact("rd000", 1'b0, 32'h000, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0);

      xact("bp_rd10", 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDE22_BE44, 1'b0);

      // Reset one cycle after accepting a write drops it entirely.
      xact("wr20_zero", 1'b1, 32'h20, 32'h0000_0000, 4'hF, 0, 32'h0, 1'b0);
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid) seen++;
         tick();
      end
      check("mid_rst_no_resp", seen, 0);
      xact("rd20", 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h0000_0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the CPU's data port. It replaces the zero-latency combinational data RAM with a handshaked, fixed-latency slave.
- Accepts one read or write request at a time over a valid/ready request channel.
- Holds the request for LATENCY cycles, commits the write or samples the read, then returns a response on a valid/ready response channel.
- Intended for the multi-cycle and pipelined cores, which stall on req_ready and resp_valid.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words stored; word index = req_addr[31:2].
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
req_be  input  4  byte enables; be[i] selects bits 8i+7:8i
resp_valid  output  1  response available
resp_ready  input  1  initiator consumes response
resp_rdata  output  32  read data; 0 for writes and errors
resp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset: synchronous, active-high. It has priority over every other event.
  - On reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0, captured request cleared.
  - Memory contents are not altered by reset.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/be, load counter with LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. Decrement the counter each cycle. At the edge where counter==0, do the following and go to RESP:
    - perform the access;
    - register resp_rdata and resp_err;
    - set resp_valid=1.
  - RESP: resp_valid=1 with resp_rdata and resp_err held stable. On resp_ready, go to IDLE and clear resp_valid on that edge.
- Latency: if a request is accepted at edge N, resp_valid is first high after edge N+LATENCY. With LATENCY=1, resp_valid is high in the cycle right after acceptance.
- Throughput: a new request can be accepted no earlier than the cycle after the response handshake. Max rate is one request per LATENCY+2 cycles.
- req_ready depends only on state (IDLE). It has no combinational path from req_valid or resp_ready.
- Error checks, evaluated on the captured request:
  - err if addr[1:0]!=0;
  - err if addr[31:2] >= MEM_DEPTH.
  - On err: no memory write; resp_rdata=0; resp_err=1.
- Write: each lane with be[i]=1 updates its byte; other bytes are unchanged. be=4'b0000 is a legal no-op that still produces a response with err=0. resp_rdata=0.
- Read: returns the full 32-bit word; req_be is ignored. The value read is the memory content at the commit edge.
- req_wdata, req_addr and the other request inputs may change freely after acceptance; only the captured copy is used.
- resp_ready while resp_valid=0 is ignored.
- Reset mid-operation:
  - in BUSY: the pending write is dropped and memory is unchanged;
  - in RESP: the response is discarded and no resp_valid is seen afterwards.

Decomposition:
- Shared package mem_if_pkg:
  - state enum {IDLE, BUSY, RESP};
  - WORD_BYTES=4;
  - typedef mem_req_t {we, addr[31:0], wdata[31:0], be[3:0]} for the captured request.
- One sub-module, be_word_ram: a synchronous-write, byte-enabled word array of MEM_DEPTH entries.
  - Ports: clk, we, be[3:0], waddr, wdata, raddr, rdata.
  - Combinational read.
  - The top instantiates it and holds the FSM, counter, error logic and output registers.

Test Plan:
- Reset then idle: reset high 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Write then read, LATENCY=2:
  - write addr 0x10, data 0xDEADBEEF, be=4'hF, accepted at edge N -> resp_valid after edge N+2, err=0, rdata=0.
  - read 0x10 -> rdata=0xDEADBEEF.
- Byte enables: word 0x10 holds 0xDEADBEEF; write 0x11223344 with be=4'b0101 -> subsequent read returns 0xDE22BE44.
- Errors:
  - read addr 0x13 -> err=1, rdata=0.
  - write addr 4*MEM_DEPTH (0x1000) -> err=1.
  - read 0x0FFC afterwards shows no corruption.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid/rdata stable, req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- Reset mid-BUSY: write 0xCAFEF00D to 0x20 (word previously 0x0), assert reset one cycle after acceptance -> no resp_valid; read 0x20 returns 0x00000000.
